// File: rtl/debounce_pkg.sv
// debounce_pkg -- shared constants and helpers for the multi-channel debouncer.
//   DEF_TICK_DIV : default clk cycles per sample tick (10 ms at 100 MHz)
//   DEF_STABLE_N : default number of consecutive ticks before a new level is accepted
//   clog2()      : bits needed to hold values 0..value-1, never less than 1
package debounce_pkg;

    localparam int DEF_TICK_DIV = 1000000;
    localparam int DEF_STABLE_N = 4;

    function automatic int clog2(input int value);
        int width;
        width = 1;
        while (width < 31 && (1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// tick_gen -- free-running sample strobe generator.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   tick  : high for the single cycle in which the counter sits at TICK_DIV-1
module tick_gen
    import debounce_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    localparam int             W    = clog2(TICK_DIV);
    localparam logic [W-1:0]   LAST = W'(TICK_DIV - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (count == LAST) begin
            count <= '0;
        end else begin
            count <= count + W'(1);
        end
    end

    // Decoded straight from the counter register, so it is glitch-free and
    // reads 0 during reset (TICK_DIV is at least 2).
    assign tick = (count == LAST);

endmodule

// File: rtl/multi_debounce.sv
// multi_debounce -- CH independent debouncers sharing one sample tick.
//   clk   : system clock
//   reset : asynchronous active-low reset
//   in    : raw asynchronous channel inputs
//   level : registered debounced level per channel
//   rise  : one-clk pulse when a channel's level goes 0->1
//   fall  : one-clk pulse when a channel's level goes 1->0
//   tick  : shared sample strobe, exported for sibling blocks
module multi_debounce
    import debounce_pkg::*;
#(
    parameter int CH       = 4,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int STABLE_N = DEF_STABLE_N
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [CH-1:0] in,
    output logic [CH-1:0] level,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic          tick
);

    localparam int            CW       = clog2(STABLE_N + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_N - 1);

    logic [CH-1:0] meta;
    logic [CH-1:0] sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            meta <= '0;
            sync <= '0;
        end else begin
            meta <= in;
            sync <= meta;
        end
    end

    tick_gen #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_gen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    for (genvar i = 0; i < CH; i++) begin : g_ch
        logic [CW-1:0] cnt;
        logic          lvl_q;
        logic          rise_q;
        logic          fall_q;

        // cnt counts ticks that have already seen the mismatch; the tick that
        // finds cnt at STABLE_N-1 is the STABLE_N-th one, so it accepts.
        // Any cycle where sync agrees with the level clears progress.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                cnt    <= '0;
                lvl_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                if (sync[i] == lvl_q) begin
                    cnt <= '0;
                end else if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt    <= '0;
                        lvl_q  <= sync[i];
                        rise_q <= sync[i];
                        fall_q <= ~sync[i];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
            end
        end

        assign level[i] = lvl_q;
        assign rise[i]  = rise_q;
        assign fall[i]  = fall_q;
    end

endmodule

// File: doc/multi_debounce.md
MULTI_DEBOUNCE -- requirements
Module: multi_debounce

Interface
REQ-001 Parameter CH, default 4: number of independent debounced channels (1..32).
REQ-002 Parameter TICK_DIV, default 1000000: clk cycles per sample tick (10 ms at 100 MHz), minimum 2.
REQ-003 Parameter STABLE_N, default 4: consecutive ticks of a changed level required before acceptance, minimum 1.
REQ-004 clk  input  1  single system clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 in  input  CH  raw, asynchronous, bouncing channel inputs.
REQ-007 level  output  CH  debounced level per channel, registered.
REQ-008 rise  output  CH  one-clk pulse per channel when level goes 0->1.
REQ-009 fall  output  CH  one-clk pulse per channel when level goes 1->0.
REQ-010 tick  output  1  one-clk sample strobe, exported for sharing by sibling blocks.

Function
REQ-011 Each in bit SHALL pass through a 2-flop synchronizer; sync[i] lags in[i] by 2 clk edges.
REQ-012 Tick generator: counter 0..TICK_DIV-1, wraps to 0; tick = 1 for exactly the cycle the counter equals TICK_DIV-1.
REQ-013 Per channel, a counter cnt of width clog2(STABLE_N+1) SHALL be kept; there is no overflow because it never exceeds STABLE_N-1.
REQ-014 Any cycle with sync[i] == level[i]: cnt[i] <= 0, regardless of tick; a bounce back restarts qualification.
REQ-015 Cycle with sync[i] != level[i] and tick = 0: cnt[i] holds.
REQ-016 Cycle with sync[i] != level[i], tick = 1, cnt[i] < STABLE_N-1: cnt[i] <= cnt[i]+1.
REQ-017 Cycle with sync[i] != level[i], tick = 1, cnt[i] == STABLE_N-1: level[i] <= sync[i]; cnt[i] <= 0; rise[i] or fall[i] <= 1 on the same edge.
REQ-018 rise/fall SHALL be registered, high for exactly one clk, and never both high for the same channel.
REQ-019 Acceptance latency: the level changes on the STABLE_N-th tick at which the mismatch is present, counting the first such tick; worst case 2 + STABLE_N*TICK_DIV clk from a clean edge.
REQ-020 Channels SHALL be fully independent; simultaneous acceptances on several channels each produce their own pulses in the same cycle.
REQ-021 A mismatch arising on the same cycle as tick counts that tick.
REQ-022 Symmetry: press and release qualification use identical rules; this differs from the prior one-shot FSM, which had a fixed 4-state ladder.

Reset
REQ-023 While reset = 0: level, rise, fall, tick, all cnt, the tick counter and the synchronizer flops SHALL be 0, asynchronously.
REQ-024 Reset deassertion mid-qualification SHALL discard progress; the first tick occurs TICK_DIV cycles after the first clk edge with reset = 1.
REQ-025 A channel held at 1 through reset SHALL report level = 1 after STABLE_N ticks, with a single rise pulse.

Structure
REQ-026 A shared package debounce_pkg SHALL hold the default constants DEF_TICK_DIV, DEF_STABLE_N, and the clog2 helper function.
REQ-027 Sub-module tick_gen (parameter TICK_DIV; ports clk, reset, tick) SHALL implement REQ-012; per-channel logic SHALL be a generate loop within multi_debounce.

Verification (bench parameters: CH=4, TICK_DIV=4, STABLE_N=3)
REQ-028 Clean press: in[0] 0->1 and held -> level[0]=1 and rise[0] pulse for one clk at the 3rd tick after sync; no other channel toggles.
REQ-029 Bounce: in[1]=1 for 6 clk, then 0 for 2 clk, then 1 and held -> cnt restarts at the drop; level[1] rises only 3 ticks after the final edge.
REQ-030 Release: level[2]=1, in[2] -> 0 and held -> fall[2] pulse and level[2]=0 at the 3rd tick; rise[2] stays 0 throughout.
REQ-031 Simultaneous: in=4'b1111 on one clk -> rise=4'b1111 in the same single cycle.
REQ-032 Reset mid-qualification: in[3]=1, reset=0 after 2 ticks for 3 clk -> all outputs 0 immediately; level[3] rises 3 ticks after release.
REQ-033 Tick period: tick is high exactly 1 of every 4 clk across 100 cycles.
